// File: rtl/ccip_c1_wr_arbiter_if.sv
// CCI-P channel 1 payload types and the requester/platform bundle seen by ccip_c1_wr_arbiter.
// master modport = environment (requesters + platform), slave modport = the arbiter.
package ccip_c1_arb_pkg;

  typedef enum logic [3:0] {
    eREQ_WRLINE_I = 4'h0,
    eREQ_WRLINE_M = 4'h1,
    eREQ_WRPUSH_I = 4'h2,
    eREQ_WRFENCE  = 4'h4,
    eREQ_INTR     = 4'h6
  } t_ccip_c1_req;

  typedef enum logic [1:0] {
    eCL_LEN_1 = 2'b00,
    eCL_LEN_2 = 2'b01,
    eCL_LEN_4 = 2'b11
  } t_ccip_clLen;

  typedef struct packed {
    logic [5:0]   rsvd2;
    logic [1:0]   vc_sel;
    logic         sop;
    logic         rsvd1;
    t_ccip_clLen  cl_len;
    t_ccip_c1_req req_type;
    logic [5:0]   rsvd0;
    logic [41:0]  address;
    logic [15:0]  mdata;
  } t_ccip_c1_ReqMemHdr;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    logic [511:0]       data;
    logic               valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    logic [1:0]  vc_used;
    logic        rsvd1;
    logic        hit_miss;
    logic        format;
    logic        rsvd0;
    logic [1:0]  cl_num;
    logic [3:0]  resp_type;
    logic [15:0] mdata;
  } t_ccip_c1_RspMemHdr;

  typedef struct packed {
    t_ccip_c1_RspMemHdr hdr;
    logic               rspValid;
  } t_if_ccip_c1_Rx;

endpackage

interface ccip_c1_wr_arbiter_if #(parameter int unsigned NUM_REQ = 4);
  import ccip_c1_arb_pkg::*;

  t_if_ccip_c1_Tx     req_c1Tx [NUM_REQ];
  logic [NUM_REQ-1:0] req_ready;
  t_if_ccip_c1_Rx     req_c1Rx [NUM_REQ];
  logic               c1TxAlmFull;
  t_if_ccip_c1_Tx     c1Tx;
  t_if_ccip_c1_Rx     c1Rx;

  modport master (
    output req_c1Tx, input req_ready, input req_c1Rx,
    output c1TxAlmFull, input c1Tx, output c1Rx
  );

  modport slave (
    input req_c1Tx, output req_ready, output req_c1Rx,
    input c1TxAlmFull, output c1Tx, input c1Rx
  );

endinterface

// File: rtl/ccip_c1_wr_arbiter.sv
// Round-robin arbiter sharing CCI-P channel 1 TX among NUM_REQ requesters, packet-atomic, with mdata tag routing of RX.
// Optional protocol checker (sticky proto_err, offending beats dropped) enabled by `define CCIP_C1_ARB_CHECK_EN.
module ccip_c1_wr_arbiter
  import ccip_c1_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                 pClk,
  input  logic                 pClk_rst_n,
  ccip_c1_wr_arbiter_if.slave  bus
`ifdef CCIP_C1_ARB_CHECK_EN
  ,
  output logic [NUM_REQ-1:0]   proto_err
`endif
);

  localparam int unsigned    IDW     = $clog2(NUM_REQ);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_REQ - 1);

  logic [IDW-1:0]     rr_ptr;
  logic [IDW-1:0]     lock_id;
  logic               lock;
  logic [1:0]         beats_left;

  logic [IDW-1:0]     sel_c;
  logic               sel_vld_c;
  logic [IDW-1:0]     nxt_ptr_c;
  logic [IDW-1:0]     rsp_id_c;
  logic [NUM_REQ-1:0] valid_c;
  logic [NUM_REQ-1:0] ready_c;
  logic               accept_c;
  logic               fwd_c;
  logic               multi_c;
  int unsigned        idx_c;
  t_ccip_c1_ReqMemHdr hdr_c;
  t_ccip_c1_RspMemHdr rsp_hdr_c;

  t_if_ccip_c1_Tx     tx_q;
  t_if_ccip_c1_Rx     rx_q [NUM_REQ];

  // Grant selection: locked owner, else first valid scanning from rr_ptr
  always_comb begin
    sel_c     = rr_ptr;
    sel_vld_c = 1'b0;
    idx_c     = 0;
    valid_c   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      valid_c[i] = bus.req_c1Tx[i].valid;
    end
    if (lock) begin
      sel_c     = lock_id;
      sel_vld_c = 1'b1;
    end else begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        idx_c = 32'(rr_ptr) + k;
        if (idx_c >= NUM_REQ) idx_c = idx_c - NUM_REQ;
        if (!sel_vld_c && valid_c[IDW'(idx_c)]) begin
          sel_c     = IDW'(idx_c);
          sel_vld_c = 1'b1;
        end
      end
    end
    ready_c = '0;
    if (pClk_rst_n && sel_vld_c && !bus.c1TxAlmFull) ready_c[sel_c] = 1'b1;
    accept_c = |(valid_c & ready_c);
  end

  // Selected beat decode and requester tagging
  always_comb begin
    hdr_c                  = bus.req_c1Tx[sel_c].hdr;
    hdr_c.mdata[15 -: IDW] = sel_c;
    multi_c = hdr_c.sop
            && (hdr_c.req_type inside {eREQ_WRLINE_I, eREQ_WRLINE_M, eREQ_WRPUSH_I})
            && (hdr_c.cl_len != eCL_LEN_1);
    nxt_ptr_c = (sel_c == LAST_ID) ? '0 : sel_c + IDW'(1);
  end

`ifdef CCIP_C1_ARB_CHECK_EN
  logic [NUM_REQ-1:0] own_c;
  logic [NUM_REQ-1:0] err_c;

  // A beat is malformed if it breaks sop framing relative to this requester's lock
  always_comb begin
    own_c = '0;
    err_c = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      own_c[i] = lock && (lock_id == IDW'(i));
      err_c[i] = bus.req_c1Tx[i].valid
              && ((!bus.req_c1Tx[i].hdr.sop && !own_c[i])
               || (bus.req_c1Tx[i].hdr.sop && own_c[i] && (beats_left != 2'd0)));
    end
    fwd_c = accept_c && !err_c[sel_c];
  end

  always_ff @(posedge pClk or negedge pClk_rst_n) begin
    if (!pClk_rst_n) proto_err <= '0;
    else             proto_err <= proto_err | err_c;
  end
`else
  always_comb fwd_c = accept_c;
`endif

  // Packet lock and round-robin pointer
  always_ff @(posedge pClk or negedge pClk_rst_n) begin
    if (!pClk_rst_n) begin
      rr_ptr     <= '0;
      lock_id    <= '0;
      lock       <= 1'b0;
      beats_left <= 2'd0;
    end else if (fwd_c) begin
      if (lock) begin
        beats_left <= beats_left - 2'd1;
        if (beats_left == 2'd1) begin
          lock   <= 1'b0;
          rr_ptr <= nxt_ptr_c;
        end
      end else if (multi_c) begin
        lock       <= 1'b1;
        lock_id    <= sel_c;
        beats_left <= (hdr_c.cl_len == eCL_LEN_2) ? 2'd1 : 2'd3;
      end else begin
        rr_ptr <= nxt_ptr_c;
      end
    end
  end

  // TX output stage: one beat in flight, payload held when idle
  always_ff @(posedge pClk or negedge pClk_rst_n) begin
    if (!pClk_rst_n) begin
      tx_q <= '0;
    end else begin
      tx_q.valid <= fwd_c;
      if (fwd_c) begin
        tx_q.hdr  <= hdr_c;
        tx_q.data <= bus.req_c1Tx[sel_c].data;
      end
    end
  end

  always_comb begin
    rsp_id_c                   = bus.c1Rx.hdr.mdata[15 -: IDW];
    rsp_hdr_c                  = bus.c1Rx.hdr;
    rsp_hdr_c.mdata[15 -: IDW] = '0;
  end

  // RX steering: tags beyond NUM_REQ-1 match no requester and are dropped
  always_ff @(posedge pClk or negedge pClk_rst_n) begin
    if (!pClk_rst_n) begin
      for (int j = 0; j < NUM_REQ; j++) rx_q[j] <= '0;
    end else begin
      for (int j = 0; j < NUM_REQ; j++) begin
        rx_q[j].rspValid <= 1'b0;
        if (bus.c1Rx.rspValid && (rsp_id_c == IDW'(j))) begin
          rx_q[j].rspValid <= 1'b1;
          rx_q[j].hdr      <= rsp_hdr_c;
        end
      end
    end
  end

  assign bus.req_ready = ready_c;
  assign bus.c1Tx      = tx_q;
  assign bus.req_c1Rx  = rx_q;

endmodule
